// File: rtl/nios_dbg_sysclk_bridge.sv
// nios_dbg_sysclk_bridge
//   System-clock half of the Nios debug slave. The TCK-domain update strobes
//   (vs_udr, vs_uir) are brought into clk through flop chains. A rising
//   vs_udr captures the scan register and instruction. One cycle later the
//   bridge emits a one-hot action/no-action pulse on the selected channel,
//   provided that channel is enabled. The consumer then holds off further
//   commands until it acks. Updates that arrive while a command is still
//   outstanding are dropped and counted.
//
// Ports
//   clk, reset_n     system clock, async active-low reset
//   ir_in, sr        TCK-domain instruction / scan data (stable around vs_udr)
//   vs_udr, vs_uir   async update-DR / update-IR levels
//   ch_mask          per-channel enable, sampled at capture
//   ack              consumer done with current command
//   jdo, ir_q        captured scan data / instruction
//   take_action      one-cycle one-hot pulse when jdo[ACT_BIT]=1
//   take_no_action   one-cycle one-hot pulse when jdo[ACT_BIT]=0
//   busy             command outstanding
//   overrun          sticky: an update was dropped (cleared by update-IR)
//   overrun_cnt      saturating count of dropped updates (cleared by reset only)

// Strobe synchroniser. The chain has STAGES synchronising flops plus one
// delay flop. rise marks the first synchronised cycle of a high level.
module nios_dbg_sysclk_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise
);
   logic [STAGES:0] pipe;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pipe <= '0;
      else          pipe <= {pipe[STAGES-1:0], d};
   end

   assign rise = pipe[STAGES-1] & ~pipe[STAGES];
endmodule

module nios_dbg_sysclk_bridge #(
   parameter int IR_W        = 2,
   parameter int DATA_W      = 38,
   parameter int ACT_BIT     = 35,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [IR_W-1:0]        ir_in,
   input  logic [DATA_W-1:0]      sr,
   input  logic                   vs_udr,
   input  logic                   vs_uir,
   input  logic [(1<<IR_W)-1:0]   ch_mask,
   input  logic                   ack,
   output logic [DATA_W-1:0]      jdo,
   output logic [IR_W-1:0]        ir_q,
   output logic [(1<<IR_W)-1:0]   take_action,
   output logic [(1<<IR_W)-1:0]   take_no_action,
   output logic                   busy,
   output logic                   overrun,
   output logic [7:0]             overrun_cnt
);
   localparam int NUM_CH = 2**IR_W;

   typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK} state_t;

   // strobe[0] = update-DR, strobe[1] = update-IR
   logic [1:0] strobe, ev;
   logic       upd, uir_ev;

   assign strobe = {vs_uir, vs_udr};

   for (genvar g = 0; g < 2; g++) begin : g_sync
      nios_dbg_sysclk_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (strobe[g]),
         .rise    (ev[g])
      );
   end

   assign upd    = ev[0];
   assign uir_ev = ev[1];

   state_t              state, state_n;
   logic                m, m_n;          // enable of the captured channel
   logic [DATA_W-1:0]   jdo_n;
   logic [IR_W-1:0]     ir_n;
   logic [NUM_CH-1:0]   act_n, nact_n;
   logic                busy_n, ovr_n;
   logic [7:0]          cnt_n;
   logic [7:0]          cnt_inc;

   assign cnt_inc = (overrun_cnt == 8'hFF) ? overrun_cnt : overrun_cnt + 8'd1;

   always_comb begin
      state_n = state;
      m_n     = m;
      jdo_n   = jdo;
      ir_n    = ir_q;
      act_n   = '0;
      nact_n  = '0;
      busy_n  = busy;
      ovr_n   = overrun;
      cnt_n   = overrun_cnt;

      if (uir_ev) begin
         // Update-IR aborts everything. A simultaneous upd is lost uncounted.
         state_n = IDLE;
         busy_n  = 1'b0;
         ovr_n   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (upd) begin
                  jdo_n   = sr;
                  ir_n    = ir_in;
                  m_n     = ch_mask[ir_in];
                  state_n = FIRE;
               end
            end
            FIRE: begin
               if (upd) begin
                  ovr_n = 1'b1;
                  cnt_n = cnt_inc;
               end
               if (m) begin
                  if (jdo[ACT_BIT]) act_n[ir_q]  = 1'b1;
                  else              nact_n[ir_q] = 1'b1;
                  busy_n  = 1'b1;
                  state_n = WAIT_ACK;
               end else begin
                  state_n = IDLE;
               end
            end
            WAIT_ACK: begin
               if (ack) begin
                  busy_n = 1'b0;
                  if (upd) begin
                     // The ack frees the slot in time for this update.
                     jdo_n   = sr;
                     ir_n    = ir_in;
                     m_n     = ch_mask[ir_in];
                     state_n = FIRE;
                  end else begin
                     state_n = IDLE;
                  end
               end else if (upd) begin
                  ovr_n = 1'b1;
                  cnt_n = cnt_inc;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         m              <= 1'b0;
         jdo            <= '0;
         ir_q           <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         busy           <= 1'b0;
         overrun        <= 1'b0;
         overrun_cnt    <= '0;
      end else begin
         state          <= state_n;
         m              <= m_n;
         jdo            <= jdo_n;
         ir_q           <= ir_n;
         take_action    <= act_n;
         take_no_action <= nact_n;
         busy           <= busy_n;
         overrun        <= ovr_n;
         overrun_cnt    <= cnt_n;
      end
   end
endmodule
